count_seg7_display: RTL and testbench

// - Display stage downstream of the 0..99 tick counter: consumes its 8-bit count and per-tick enable pulse.
// - Converts the captured binary value to tens/ones BCD with an iterative subtract-by-10 FSM.
// - Drives two active-low 7-segment digit registers for the board.
// - Values above 99 show "--" and raise an overflow flag.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_digit_dec.sv | 17 +
 rtl/count_seg7_display.sv | 124 ++++++++++++
 tb/tb_count_seg7_display.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment display stage.
package seg7_pkg;

   typedef enum logic {
      IDLE,
      SUB
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam int         BCD_MAX   = 99;

   // Active-low {g,f,e,d,c,b,a} codes; index 9 is the leftmost entry.
   localparam logic [9:0][6:0] DIGIT_CODE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD digit to active-low 7-segment decoder.
module seg7_digit_dec
   import seg7_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   // Codes 10..15 cannot come from the converter, so they fall back to blank.
   always_comb begin
      o_seg = SEG_BLANK;
      if (i_digit < 4'd10) begin
         o_seg = DIGIT_CODE[i_digit];
      end
   end

endmodule

// File: rtl/count_seg7_display.sv
// Captures a binary count, converts it to tens/ones by repeated subtraction
// of 10, and holds the result in two active-low 7-segment registers.
module count_seg7_display
   import seg7_pkg::*;
#(
   parameter bit BLANK_LZ = 1'b1,
   parameter int WIDTH    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             val_i,
   input  logic [WIDTH-1:0] value_i,
   output logic [6:0]       seg_tens_o,
   output logic [6:0]       seg_ones_o,
   output logic             busy_o,
   output logic             ovf_o,
   output logic             drop_o
);

   localparam logic [WIDTH-1:0] MAX_VALUE = WIDTH'(BCD_MAX);

   state_t     r_state;
   state_t     w_stateNext;
   logic [6:0] r_rem;
   logic [3:0] r_tens;
   logic [6:0] r_segTens;
   logic [6:0] r_segOnes;
   logic       r_ovf;
   logic       r_drop;
   logic       w_overRange;
   logic       w_remDone;
   logic [6:0] w_tensCode;
   logic [6:0] w_onesCode;

   assign w_overRange = (value_i > MAX_VALUE);
   assign w_remDone   = (r_rem < 7'd10);

   seg7_digit_dec u_tensDec (
      .i_digit (r_tens),
      .o_seg   (w_tensCode)
   );

   seg7_digit_dec u_onesDec (
      .i_digit (r_rem[3:0]),
      .o_seg   (w_onesCode)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (val_i && !w_overRange) begin
               w_stateNext = SUB;
            end
         end
         SUB: begin
            if (w_remDone) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // The display registers change only on the final SUB edge or an
   // out-of-range capture, so partial quotients never reach the pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem     <= '0;
         r_tens    <= '0;
         r_segTens <= SEG_BLANK;
         r_segOnes <= SEG_BLANK;
         r_ovf     <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_drop <= 1'b0;
         case (r_state)
            IDLE: begin
               if (val_i) begin
                  if (w_overRange) begin
                     r_segTens <= SEG_DASH;
                     r_segOnes <= SEG_DASH;
                     r_ovf     <= 1'b1;
                  end else begin
                     r_rem  <= value_i[6:0];
                     r_tens <= '0;
                     r_ovf  <= 1'b0;
                  end
               end
            end
            SUB: begin
               r_drop <= val_i;
               if (w_remDone) begin
                  r_segOnes <= w_onesCode;
                  if (BLANK_LZ && (r_tens == 4'd0)) begin
                     r_segTens <= SEG_BLANK;
                  end else begin
                     r_segTens <= w_tensCode;
                  end
               end else begin
                  r_rem  <= r_rem - 7'd10;
                  r_tens <= r_tens + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o     = (r_state == SUB);
   assign seg_tens_o = r_segTens;
   assign seg_ones_o = r_segOnes;
   assign ovf_o      = r_ovf;
   assign drop_o     = r_drop;

endmodule

// File: tb/tb_count_seg7_display.sv
// Directed bench for count_seg7_display with hand-computed segment codes.
module tb_count_seg7_display;

   logic       clk;
   logic       rst;
   logic       valI;
   logic [7:0] valueI;
   logic [6:0] segTens;
   logic [6:0] segOnes;
   logic       busy;
   logic       ovf;
   logic       drop;

   int checkCount;
   int failCount;

   count_seg7_display #(
      .BLANK_LZ (1'b1),
      .WIDTH    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .val_i      (valI),
      .value_i    (valueI),
      .seg_tens_o (segTens),
      .seg_ones_o (segOnes),
      .busy_o     (busy),
      .ovf_o      (ovf),
      .drop_o     (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle 1 time unit past it before sampling.
   task automatic applyStimulus(input logic v, input logic [7:0] value, input logic r);
      valI   = v;
      valueI = value;
      rst    = r;
      @(posedge clk);
      #1;
      valI = 1'b0;
      rst  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkDisplay(input string tag, input logic [6:0] t, input logic [6:0] o,
                               input logic b, input logic f);
      checkOutput({tag, "_tens"}, {1'b0, segTens}, {1'b0, t});
      checkOutput({tag, "_ones"}, {1'b0, segOnes}, {1'b0, o});
      checkOutput({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
      checkOutput({tag, "_ovf"},  {7'd0, ovf},  {7'd0, f});
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      valI   = 1'b0;
      valueI = 8'd0;
      rst    = 1'b1;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b1);
      checkDisplay("reset", 7'h7F, 7'h7F, 1'b0, 1'b0);
      checkOutput("reset_drop", {7'd0, drop}, 8'd0);

      applyStimulus(1'b1, 8'd0, 1'b0);
      checkDisplay("v0_k", 7'h7F, 7'h7F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v0_k1", 7'h7F, 7'h40, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd57, 1'b0);
      checkDisplay("v57_k", 7'h7F, 7'h40, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 8'd0, 1'b0);
         checkDisplay("v57_hold", 7'h7F, 7'h40, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v57_k6", 7'h12, 7'h78, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd99, 1'b0);
      for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v99_k9", 7'h12, 7'h78, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v99_k10", 7'h10, 7'h10, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd150, 1'b0);
      checkDisplay("v150", 7'h3F, 7'h3F, 1'b0, 1'b1);

      applyStimulus(1'b1, 8'd40, 1'b0);
      checkDisplay("v40_k", 7'h3F, 7'h3F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("v40_k1_drop", {7'd0, drop}, 8'd0);
      applyStimulus(1'b1, 8'd7, 1'b0);
      checkOutput("v40_k2_drop", {7'd0, drop}, 8'd1);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("v40_k3_drop", {7'd0, drop}, 8'd0);
      checkDisplay("v40_k3", 7'h3F, 7'h3F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v40_k4", 7'h3F, 7'h3F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v40_k5", 7'h19, 7'h40, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v40_after", 7'h19, 7'h40, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd80, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v80_k2", 7'h19, 7'h40, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkDisplay("v80_rst", 7'h7F, 7'h7F, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v80_norewrite", 7'h7F, 7'h7F, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd100, 1'b0);
      checkDisplay("v100", 7'h3F, 7'h3F, 1'b0, 1'b1);

      applyStimulus(1'b1, 8'd10, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v10_k1", 7'h3F, 7'h3F, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v10_k2", 7'h79, 7'h40, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd9, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkDisplay("v9_k1", 7'h7F, 7'h10, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'd255, 1'b0);
      checkDisplay("v255", 7'h3F, 7'h3F, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
